// File: rtl/aes_pkg.sv
// aes_pkg: shared AES tables, helpers and engine state type
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} engine_state_t;

    localparam int KEY_BITS_128 = 128;
    localparam int KEY_BITS_256 = 256;

    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [15:0][7:0] RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

    function automatic int nr_of(input int key_bits);
        return (key_bits == KEY_BITS_256) ? 14 : 10;
    endfunction

    // Table is stored with byte 0x00's entry in the top slot, hence the inverted index
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return RCON[i];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 of a word sits at the LSB, so rotating left in byte order is a right shift
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    // Four chained word XORs that turn an older key block plus the mixed word into a new block
    function automatic logic [127:0] chain(input logic [127:0] prev, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = prev[31:0] ^ t;
        w1 = prev[63:32] ^ w0;
        w2 = prev[95:64] ^ w1;
        w3 = prev[127:96] ^ w2;
        return {w3, w2, w1, w0};
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: combinational SubBytes, ShiftRows, optional MixColumns and AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_sub, w_shift, w_mix;

    for (genvar k = 0; k < 16; k++) begin : g_sub
        assign w_sub[8*k +: 8] = sbox(i_state[8*k +: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shift[8*(4*c+r) +: 8] = w_sub[8*(4*((c+r)%4)+r) +: 8];
        end
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign {w_a3, w_a2, w_a1, w_a0} = w_shift[32*c +: 32];
        assign w_mix[32*c +: 8]    = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mix[32*c+8 +: 8]  = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mix[32*c+16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mix[32*c+24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    assign o_state = (i_last ? w_shift : w_mix) ^ i_key;

endmodule

// File: rtl/aes_engine.sv
// aes_engine: iterative AES-128/256 encryptor, one round per clock, on-the-fly key expansion
module aes_engine
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy,
    output logic [3:0]          round
);

    localparam int NR = nr_of(KEY_BITS);

    engine_state_t       r_state, w_next;
    logic [127:0]        r_data, r_out, w_rk, w_round;
    logic [KEY_BITS-1:0] r_key, w_key_next;
    logic [3:0]          r_round;
    logic                w_accept, w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_round == 4'(NR));

    if (KEY_BITS == KEY_BITS_128) begin : g_k128
        assign w_rk       = chain(r_key, sub_word(rot_word(r_key[127:96])) ^ {24'h0, rcon(r_round)});
        assign w_key_next = w_rk;
    end else if (KEY_BITS == KEY_BITS_256) begin : g_k256
        // Window holds the two most recent round keys; round 1 simply uses the upper half
        logic [31:0]  w_t;
        logic [127:0] w_new;
        assign w_t        = r_round[0] ? sub_word(r_key[255:224])
                                       : sub_word(rot_word(r_key[255:224])) ^ {24'h0, rcon(r_round >> 1)};
        assign w_new      = chain(r_key[127:0], w_t);
        assign w_rk       = (r_round == 4'd1) ? r_key[255:128] : w_new;
        assign w_key_next = (r_round == 4'd1) ? r_key : {w_new, r_key[255:128]};
    end else begin : g_bad
        $error("aes_engine: KEY_BITS must be 128 or 256");
    end

    aes_round u_round (
        .i_state (r_data),
        .i_key   (w_rk),
        .i_last  (w_last),
        .o_state (w_round)
    );

    // Engine state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state: accept in IDLE, finish after the last round, release on output handshake
    always_comb begin
        w_next = (r_state == IDLE && in_valid)   ? ROUND :
                 (r_state == ROUND && w_last)    ? DONE  :
                 (r_state == DONE && out_ready)  ? IDLE  : r_state;
    end

    // Datapath: load the whitened block, iterate rounds, capture the ciphertext
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_data  <= in_data ^ in_key[127:0];
            r_key   <= in_key;
            r_round <= 4'd1;
        end else if (r_state == ROUND) begin
            r_data  <= w_round;
            r_key   <= w_key_next;
            r_round <= w_last ? r_round : r_round + 4'd1;
            r_out   <= w_last ? w_round : r_out;
        end else if (r_state == DONE && out_ready) begin
            r_round <= '0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign round     = r_round;
    assign out_data  = r_out;

endmodule

// File: tb/tb_aes_engine.sv
// tb_aes_engine: directed and randomized checks of both AES key sizes against a FIPS-197 model
module tb_aes_engine;

    localparam logic [127:0] KAT_PT    = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] KAT_K128  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] KAT_K256  = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] KAT_CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] KAT_CT256 = 128'h8960494b9049fceabf456751cab7a28e;

    logic         clock = 0, reset_n = 0, v128 = 0, v256 = 0, out_ready = 0;
    logic [127:0] in_data = '0, key128 = '0;
    logic [255:0] key256 = '0;
    logic         rdy128, ov128, busy128, rdy256, ov256, busy256;
    logic [3:0]   rnd128, rnd256;
    logic [127:0] od128, od256;

    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    logic [7:0] sb [256];

    aes_engine #(.KEY_BITS(128)) u128 (
        .clock(clock), .reset_n(reset_n), .in_valid(v128), .in_ready(rdy128),
        .in_data(in_data), .in_key(key128), .out_valid(ov128), .out_ready(out_ready),
        .out_data(od128), .busy(busy128), .round(rnd128)
    );

    aes_engine #(.KEY_BITS(256)) u256 (
        .clock(clock), .reset_n(reset_n), .in_valid(v256), .in_ready(rdy256),
        .in_data(in_data), .in_key(key256), .out_valid(ov256), .out_ready(out_ready),
        .out_data(od256), .busy(busy256), .round(rnd256)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Full FIPS-197 cipher: expand the whole key schedule, then run the rounds on a 4x4 byte matrix
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
        logic [7:0] w [60][4];
        logic [7:0] s [4][4];
        logic [7:0] n [4][4];
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [127:0] ct;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = '{sb[w[i-1][1]] ^ rc, sb[w[i-1][2]], sb[w[i-1][3]], sb[w[i-1][0]]};
                rc = gmul(rc, 8'h02);
            end else if (nk > 4 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[8*(r+4*c) +: 8] ^ w[c][r];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) n[r][c] = sb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rd < nr) begin
                    s[0][c] = gmul(8'h02, n[0][c]) ^ gmul(8'h03, n[1][c]) ^ n[2][c] ^ n[3][c];
                    s[1][c] = n[0][c] ^ gmul(8'h02, n[1][c]) ^ gmul(8'h03, n[2][c]) ^ n[3][c];
                    s[2][c] = n[0][c] ^ n[1][c] ^ gmul(8'h02, n[2][c]) ^ gmul(8'h03, n[3][c]);
                    s[3][c] = gmul(8'h03, n[0][c]) ^ n[1][c] ^ n[2][c] ^ gmul(8'h02, n[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = n[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rd+c][r];
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ct[8*(r+4*c) +: 8] = s[r][c];
        return ct;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one block, wait (bounded) for out_valid; lat counts edges from accept to out_valid
    task automatic send(input bit big, input logic [255:0] key, input logic [127:0] pt,
                        output logic [127:0] ct, output int lat);
        check("in_ready_before_send", 256'(big ? rdy256 : rdy128), 256'(1));
        in_data = pt;
        if (big) begin key256 = key; v256 = 1; end
        else     begin key128 = key[127:0]; v128 = 1; end
        step();
        acc_cyc = cyc;
        v128 = 0;
        v256 = 0;
        check("busy_after_accept", 256'({big ? busy256 : busy128, big ? rnd256 : rnd128}), 256'({1'b1, 4'd1}));
        lat = 0;
        while (!(big ? ov256 : ov128) && lat < 40) begin
            step();
            lat++;
        end
        ct = big ? od256 : od128;
    endtask

    initial begin
        logic [127:0] ct, pt, ex;
        logic [255:0] k;
        int lat, prev;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        reset_n = 0;
        step();
        step();
        check("reset128_status", 256'({rdy128, ov128, busy128, rnd128}), 256'({3'b100, 4'd0}));
        check("reset128_data", 256'(od128), 256'(0));
        check("reset256_status", 256'({rdy256, ov256, busy256, rnd256}), 256'({3'b100, 4'd0}));
        check("reset256_data", 256'(od256), 256'(0));
        reset_n = 1;
        step();

        out_ready = 1;
        send(0, 256'(KAT_K128), KAT_PT, ct, lat);
        check("kat128_latency", 256'(lat), 256'(10));
        check("kat128_ct", 256'(ct), 256'(KAT_CT128));
        check("kat128_round_done", 256'(rnd128), 256'(10));
        step();
        check("kat128_released", 256'({ov128, rdy128, busy128, rnd128}), 256'({3'b010, 4'd0}));
        check("kat128_data_kept", 256'(od128), 256'(KAT_CT128));

        send(1, KAT_K256, KAT_PT, ct, lat);
        check("kat256_latency", 256'(lat), 256'(14));
        check("kat256_ct", 256'(ct), 256'(KAT_CT256));
        check("kat256_round_done", 256'(rnd256), 256'(14));
        step();
        check("kat256_released", 256'({ov256, rdy256, busy256}), 256'(3'b010));

        out_ready = 0;
        k = rand256();
        pt = {$urandom, $urandom, $urandom, $urandom};
        ex = aes_ref({128'h0, k[127:0]}, 4, pt);
        send(0, k, pt, ct, lat);
        check("bp_latency", 256'(lat), 256'(10));
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_data_stable", 256'(od128), 256'(ex));
            check("bp_status", 256'({ov128, rdy128, busy128}), 256'(3'b101));
        end
        out_ready = 1;
        step();
        out_ready = 0;
        check("bp_handshake", 256'({ov128, rdy128, busy128}), 256'(3'b010));
        step();
        check("bp_single_handshake", 256'({ov128, rdy128, busy128}), 256'(3'b010));

        k = rand256();
        pt = {$urandom, $urandom, $urandom, $urandom};
        ex = aes_ref(k, 8, pt);
        in_data = pt;
        key256 = k;
        v256 = 1;
        step();
        lat = 0;
        while (!ov256 && lat < 40) begin
            check("stab_no_ready", 256'(rdy256), 256'(0));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            key256 = rand256();
            v256 = ~v256;
            step();
            lat++;
        end
        v256 = 0;
        check("stab_latency", 256'(lat), 256'(14));
        check("stab_ct", 256'(od256), 256'(ex));
        out_ready = 1;
        step();
        out_ready = 0;
        check("stab_released", 256'({ov256, rdy256, busy256, rnd256}), 256'({3'b010, 4'd0}));

        in_data = KAT_PT;
        key128 = KAT_K128;
        v128 = 1;
        step();
        v128 = 0;
        lat = 0;
        while (rnd128 != 4'd5 && lat < 40) begin
            step();
            lat++;
        end
        check("rst_reached_round5", 256'(rnd128), 256'(5));
        reset_n = 0;
        #1;
        check("rst_immediate", 256'({ov128, rdy128, busy128, rnd128}), 256'({3'b010, 4'd0}));
        check("rst_data", 256'(od128), 256'(0));
        step();
        check("rst_held", 256'({ov128, rdy128, busy128}), 256'(3'b010));
        reset_n = 1;
        step();
        out_ready = 1;
        send(0, 256'(KAT_K128), KAT_PT, ct, lat);
        check("rst_kat_latency", 256'(lat), 256'(10));
        check("rst_kat_ct", 256'(ct), 256'(KAT_CT128));
        step();

        prev = 0;
        for (int b = 0; b < 3; b++) begin
            k = rand256();
            pt = {$urandom, $urandom, $urandom, $urandom};
            send(1, k, pt, ct, lat);
            check("b2b_ct", 256'(ct), 256'(aes_ref(k, 8, pt)));
            check("b2b_latency", 256'(lat), 256'(14));
            if (b > 0) check("b2b_period", 256'(acc_cyc - prev), 256'(16));
            prev = acc_cyc;
            step();
        end
        for (int b = 0; b < 2; b++) begin
            k = rand256();
            pt = {$urandom, $urandom, $urandom, $urandom};
            send(0, k, pt, ct, lat);
            check("b2b128_ct", 256'(ct), 256'(aes_ref({128'h0, k[127:0]}, 4, pt)));
            if (b > 0) check("b2b128_period", 256'(acc_cyc - prev), 256'(12));
            prev = acc_cyc;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
